// File: rtl/alu_pkg.sv
// Shared ALU types and helpers for the shift sequencer.
// Holds the FSM state type, the direction codes and the amount clamp.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  function automatic int unsigned clamp_amt(
    input int unsigned amt,
    input int unsigned n
  );
    return (amt > n) ? n : amt;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift step: moves data one place in either direction.
// Returns the shifted word and the bit that fell off the end.
module shift_step
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] data,
  input  logic         dir,
  input  logic         fill,
  output logic [N-1:0] nxt,
  output logic         bit_out
);

  // single shift; fill only enters from the top on right shifts
  always_comb begin
    nxt     = data;
    bit_out = 1'b0;
    if (dir == DIR_RIGHT) begin
      nxt     = {fill, data[N-1:1]};
      bit_out = data[0];
    end else begin
      nxt     = {data[N-2:0], 1'b0};
      bit_out = data[N-1];
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: one 1-bit shift per clock, valid/ready on both sides.
// Optional macro SHIFT_SEQ_ARITH_EN adds in_arith for sign-filling right shifts.
module shift_seq
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [AW-1:0] in_amt,
`ifdef SHIFT_SEQ_ARITH_EN
  input  logic          in_arith,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero,
  output logic          busy
);

  shift_state_t  state_q;
  shift_state_t  state_d;
  logic [N-1:0]  data_q;
  logic [AW-1:0] cnt_q;
  logic          carry_q;
  logic          dir_q;
  logic          fill;
  logic          accept;
  logic [AW-1:0] amt_c;
  logic [N-1:0]  step_data;
  logic          step_bit;

  assign accept = in_valid & in_ready;
  assign amt_c  = AW'(clamp_amt(32'(in_amt), N));

`ifdef SHIFT_SEQ_ARITH_EN
  logic arith_q;
  assign fill = arith_q & data_q[N-1];
`else
  assign fill = 1'b0;
`endif

  shift_step #(.N(N)) u_step (
    .data    (data_q),
    .dir     (dir_q),
    .fill    (fill),
    .nxt     (step_data),
    .bit_out (step_bit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: zero amount skips straight to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (amt_c != '0) ? SHIFT : DONE;
      SHIFT: if (cnt_q == AW'(1)) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: latch request on accept, then shift and count down
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      dir_q   <= DIR_LEFT;
    end else if (accept) begin
      data_q  <= in_data;
      cnt_q   <= amt_c;
      carry_q <= 1'b0;
      dir_q   <= in_dir;
    end else if (state_q == SHIFT) begin
      data_q  <= step_data;
      carry_q <= step_bit;
      cnt_q   <= cnt_q - AW'(1);
    end
  end

`ifdef SHIFT_SEQ_ARITH_EN
  // arithmetic mode travels with the request
  always_ff @(posedge clk) begin
    if (rst)         arith_q <= 1'b0;
    else if (accept) arith_q <= in_arith;
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_shift_seq.sv
// Randomized and directed bench for shift_seq against a reference model.
// Build with SHIFT_SEQ_ARITH_EN to also cover sign-filling right shifts.
module tb_shift_seq;

  localparam int N  = 32;
  localparam int AW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_dir;
  logic [AW-1:0] in_amt;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  shift_seq #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
`ifdef SHIFT_SEQ_ARITH_EN
    .in_arith  (in_arith),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: whole shift done at once with plain arithmetic
  task automatic model(input logic [31:0] d, input logic dir,
                       input logic ar, input int amt,
                       output logic [31:0] r, output logic c,
                       output int a);
    logic signed [63:0] sx;
    logic [63:0] w;
    a = (amt > N) ? N : amt;
    r = d;
    c = 1'b0;
    if (a != 0) begin
      if (dir) begin
        sx = ar ? {{32{d[31]}}, d} : {32'b0, d};
        sx = sx >>> a;
        r  = sx[31:0];
        c  = d[a-1];
      end else begin
        w = {32'b0, d} << a;
        r = w[31:0];
        c = d[N-a];
      end
    end
  endtask

  task automatic run_req(input logic [31:0] d, input logic dir,
                         input logic ar, input int amt,
                         input int hold, input logic poke);
    logic [31:0] er;
    logic ec;
    int a;
    int lat;
    logic arm;
`ifdef SHIFT_SEQ_ARITH_EN
    arm = ar;
`else
    arm = 1'b0;
`endif
    model(d, dir, arm, amt, er, ec, a);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_amt   = AW'(amt);
    in_arith = ar;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_dir   = ~dir;
    in_arith = ~ar;
    lat = 0;
    while (!out_valid && lat < N + 3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(a));
    chk("out_valid", 64'(out_valid), 64'(1));
    chk("out_data", 64'(out_data), 64'(er));
    chk("out_carry", 64'(out_carry), 64'(ec));
    chk("out_zero", 64'(out_zero), 64'(er == 0));
    chk("busy_done", 64'(busy), 64'(1));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_amt   = AW'(0);
      end
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(er));
      chk("hold_carry", 64'(out_carry), 64'(ec));
      chk("hold_ready", 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'(0));
    chk("release_ready", 64'(in_ready), 64'(1));
    chk("release_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_amt    = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_carry", 64'(out_carry), 64'(0));
    chk("rst_out_zero", 64'(out_zero), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    run_req(32'h8000_0003, 1'b1, 1'b0, 1, 0, 1'b0);
    run_req(32'h8000_0001, 1'b0, 1'b0, 4, 0, 1'b0);
    run_req(32'h1234_5678, 1'b1, 1'b0, 0, 0, 1'b0);
    run_req(32'hFFFF_FFFF, 1'b0, 1'b0, 40, 0, 1'b0);
    run_req(32'hFFFF_FFFF, 1'b1, 1'b0, 32, 0, 1'b0);
    run_req(32'h8000_0001, 1'b0, 1'b0, 32, 0, 1'b0);
    run_req(32'hA5A5_0F0F, 1'b1, 1'b0, 3, 5, 1'b1);
    run_req(32'h0000_00F0, 1'b1, 1'b0, 2, 0, 1'b0);

    // reset in the middle of a long shift
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_dir   = 1'b1;
    in_amt   = AW'(20);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_valid", 64'(out_valid), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_ready", 64'(in_ready), 64'(1));
    chk("mrst_data", 64'(out_data), 64'(0));
    chk("mrst_zero", 64'(out_zero), 64'(1));
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_result", 64'(seen), 64'(0));

`ifdef SHIFT_SEQ_ARITH_EN
    run_req(32'h8000_0000, 1'b1, 1'b1, 4, 0, 1'b0);
    run_req(32'h8000_0000, 1'b1, 1'b0, 4, 0, 1'b0);
    run_req(32'h8000_0001, 1'b1, 1'b1, 40, 0, 1'b0);
    run_req(32'h8000_0001, 1'b0, 1'b1, 3, 0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      run_req($urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 63)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
